// File: rtl/mstr0_burst_drain.sv
// Master-0 output stage: drains the result FIFO into bursts of up to BURST_LEN beats,
// using a one-beat look-ahead hold register so the last beat is tagged before it is presented.
module mstr0_burst_drain #(
  parameter int unsigned DW        = 32,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned IDLE_TMO  = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_rdata,
  output logic          fifo_rd,
  input  logic          flush,
  input  logic          mstr0_ack,
  output logic [DW-1:0] mstr0_data,
  output logic [1:0]    mstr0_data_valid,
  output logic [15:0]   burst_count
);

  localparam int unsigned IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned TW = $clog2(IDLE_TMO);
  localparam logic [IW-1:0] IDX_LAST = IW'(BURST_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(IDLE_TMO - 1);
  localparam logic [1:0] V_IDLE = 2'b00;
  localparam logic [1:0] V_DATA = 2'b01;
  localparam logic [1:0] V_LAST = 2'b11;

  logic          h_v;
  logic [DW-1:0] h_data;
  logic          rd_pend;
  logic          flush_pend;
  logic [IW-1:0] beat_idx;
  logic [TW-1:0] idle_cnt;

  logic o_busy;
  logic xfer;
  logic o_free;
  logic succ;
  logic cond_a;
  logic cond_c;
  logic cond_d;
  logic promote;
  logic promote_last;
  logic pipe_empty;
  logic flush_pend_nxt;

  // Promotion and read decisions; a, c and d all tag last, so priority only matters versus b.
  always_comb begin
    o_busy         = (mstr0_data_valid != V_IDLE);
    xfer           = o_busy & mstr0_ack;
    o_free         = !o_busy | mstr0_ack;
    succ           = rd_pend | !fifo_empty;
    cond_a         = (beat_idx == IDX_LAST);
    cond_c         = (idle_cnt == TMO_LAST);
    cond_d         = flush_pend & !rd_pend & fifo_empty;
    promote_last   = cond_a | cond_d | cond_c;
    promote        = h_v & o_free & (promote_last | succ);
    fifo_rd        = !fifo_empty & !rd_pend & (!h_v | promote);
    pipe_empty     = !h_v & !rd_pend & fifo_empty;
    flush_pend_nxt = flush_pend | flush;
    // A flush landing on the closing promotion is kept for the next held beat.
    if (promote && cond_d) begin
      flush_pend_nxt = flush;
    end
    if (pipe_empty) begin
      flush_pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_v              <= 1'b0;
      h_data           <= '0;
      rd_pend          <= 1'b0;
      flush_pend       <= 1'b0;
      beat_idx         <= '0;
      idle_cnt         <= '0;
      mstr0_data       <= '0;
      mstr0_data_valid <= V_IDLE;
      burst_count      <= '0;
    end else begin
      rd_pend    <= fifo_rd;
      flush_pend <= flush_pend_nxt;

      // rd_pend implies H was vacated, so capture never collides with a held beat.
      if (rd_pend) begin
        h_v    <= 1'b1;
        h_data <= fifo_rdata;
      end else if (promote) begin
        h_v <= 1'b0;
      end

      if (promote) begin
        mstr0_data       <= h_data;
        mstr0_data_valid <= promote_last ? V_LAST : V_DATA;
        beat_idx         <= promote_last ? '0 : beat_idx + IW'(1);
      end else if (xfer) begin
        mstr0_data_valid <= V_IDLE;
      end

      // Idle timer saturates so a stalled output still closes the burst once free.
      if (!h_v || succ || promote) begin
        idle_cnt <= '0;
      end else if (idle_cnt != TMO_LAST) begin
        idle_cnt <= idle_cnt + TW'(1);
      end

      if (xfer && (mstr0_data_valid == V_LAST)) begin
        burst_count <= burst_count + 16'd1;
      end
    end
  end

endmodule
